// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM encoding and default widths.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_DEPTH       = 256;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage: synchronous write, registered read, no reset on contents.
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [IDX_W-1:0]  idx;

  assign idx = addr_i[IDX_W-1:0];

  // The controller only enables either port for in-range addresses.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx] <= wdata_i;
    if (re_i) rdata_q <= mem_q[idx];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// CPU-facing memory slave: accepts one request at a time, inserts wait states,
// then holds a response until the CPU takes it.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_L  = CNT_W'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept;
  logic              commit;
  logic              cmt_write;
  logic [ADDR_W-1:0] cmt_addr;
  logic [DATA_W-1:0] cmt_wdata;
  logic              cmt_in_range;
  logic              mem_we, mem_re;
  logic [DATA_W-1:0] arr_rdata;

  assign accept = req_valid && req_ready;

  // With zero wait states the commit happens on the accept edge, so the
  // request fields are taken straight from the port instead of the latches.
  assign cmt_write    = (state_q == IDLE) ? req_write : write_q;
  assign cmt_addr     = (state_q == IDLE) ? req_addr  : addr_q;
  assign cmt_wdata    = (state_q == IDLE) ? req_wdata : wdata_q;
  assign cmt_in_range = {1'b0, cmt_addr} < DEPTH_L;
  assign commit       = (state_d == RESP) && (state_q != RESP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = WAIT_L;
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (commit) err_d = !cmt_in_range;
  end

  always_comb begin
    req_ready = (state_q == IDLE) && reset_n;
    rsp_valid = (state_q == RESP);
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = (rsp_valid && !write_q && !err_q) ? arr_rdata : '0;
    mem_we    = commit && cmt_write && cmt_in_range;
    mem_re    = commit && !cmt_write && cmt_in_range;
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem_array (
    .clk     (clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (cmt_addr),
    .wdata_i (cmt_wdata),
    .rdata_o (arr_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (default timing/depth, and a
// zero-wait 16-word variant) checked against an array-based reference.
module tb_mem_responder;

  logic       clk;
  logic       rst_n  [2];
  logic       rv     [2];
  logic       rw     [2];
  logic [7:0] ra     [2];
  logic [7:0] rwd    [2];
  logic       rrdy   [2];
  logic       sv     [2];
  logic       srdy   [2];
  logic [7:0] srd    [2];
  logic       se     [2];

  int checks = 0;
  int errors = 0;

  logic [7:0] model [2][256];
  bit         known [2][256];

  mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .reset_n(rst_n[0]), .req_valid(rv[0]), .req_write(rw[0]),
    .req_addr(ra[0]), .req_wdata(rwd[0]), .req_ready(rrdy[0]),
    .rsp_valid(sv[0]), .rsp_ready(srdy[0]), .rsp_rdata(srd[0]), .rsp_err(se[0])
  );

  mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .reset_n(rst_n[1]), .req_valid(rv[1]), .req_write(rw[1]),
    .req_addr(ra[1]), .req_wdata(rwd[1]), .req_ready(rrdy[1]),
    .rsp_valid(sv[1]), .rsp_ready(srdy[1]), .rsp_rdata(srd[1]), .rsp_err(se[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  function automatic int waitc(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int depth_of(input int d);
    return (d == 0) ? 256 : 16;
  endfunction

  // One complete transaction; starts and ends just after a falling edge.
  task automatic do_txn(input int d, input bit wr, input logic [7:0] addr,
                        input logic [7:0] wd, input int stall, input string tag);
    bit         exp_err;
    bit         chk_data;
    logic [7:0] exp_rd;
    int         lat;
    bit         got;
    exp_err  = int'(addr) >= depth_of(d);
    chk_data = wr || exp_err || known[d][addr];
    exp_rd   = (!wr && !exp_err) ? model[d][addr] : 8'h00;

    rv[d] = 1'b1; rw[d] = wr; ra[d] = addr; rwd[d] = wd;
    checks++;
    if (rrdy[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready_idle dut%0d: got %b want 1", tag, d, rrdy[d]);
    end
    @(posedge clk); @(negedge clk);
    rw[d] = 1'($urandom); ra[d] = 8'($urandom); rwd[d] = 8'($urandom);

    lat = 1; got = 0;
    while (lat <= 40) begin
      if (sv[d] === 1'b1) begin got = 1; break; end
      @(posedge clk); @(negedge clk);
      rw[d] = 1'($urandom); ra[d] = 8'($urandom); rwd[d] = 8'($urandom);
      lat++;
    end
    checks++;
    if (!got || lat != waitc(d) + 1) begin
      errors++;
      $display("FAIL %s latency dut%0d: got %0d (seen=%0b) want %0d", tag, d, lat, got, waitc(d) + 1);
    end
    if (!got) begin
      rv[d] = 1'b0;
      return;
    end

    checks++;
    if (se[d] !== exp_err) begin
      errors++;
      $display("FAIL %s rsp_err dut%0d: got %b want %b", tag, d, se[d], exp_err);
    end
    if (chk_data) begin
      checks++;
      if (srd[d] !== exp_rd) begin
        errors++;
        $display("FAIL %s rsp_rdata dut%0d: got %h want %h", tag, d, srd[d], exp_rd);
      end
    end
    srdy[d] = (stall == 0);
    if (stall == 0) rv[d] = 1'b0;

    for (int i = 1; i <= stall; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (sv[d] !== 1'b1 || se[d] !== exp_err || rrdy[d] !== 1'b0 ||
          (chk_data && srd[d] !== exp_rd)) begin
        errors++;
        $display("FAIL %s hold dut%0d cyc%0d: got v=%b e=%b rdy=%b d=%h want v=1 e=%b rdy=0 d=%h",
                 tag, d, i, sv[d], se[d], rrdy[d], srd[d], exp_err, exp_rd);
      end
      if (i == stall) begin
        srdy[d] = 1'b1;
        rv[d]   = 1'b0;
      end
    end

    @(posedge clk); @(negedge clk);
    srdy[d] = 1'b0;
    checks++;
    if (sv[d] !== 1'b0 || rrdy[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s after_handshake dut%0d: got v=%b rdy=%b want v=0 rdy=1", tag, d, sv[d], rrdy[d]);
    end

    if (wr && !exp_err) begin
      model[d][addr] = wd;
      known[d][addr] = 1'b1;
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; rv[d] = 1'b0; rw[d] = 1'b0; ra[d] = '0; rwd[d] = '0; srdy[d] = 1'b0;
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (sv[d] !== 1'b0 || rrdy[d] !== 1'b0 || se[d] !== 1'b0 || srd[d] !== 8'h00) begin
          errors++;
          $display("FAIL reset_hold dut%0d: got v=%b rdy=%b e=%b d=%h want all 0", d, sv[d], rrdy[d], se[d], srd[d]);
        end
      end
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (sv[d] !== 1'b0 || rrdy[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_release dut%0d: got v=%b rdy=%b want v=0 rdy=1", d, sv[d], rrdy[d]);
      end
    end
  endtask

  task automatic test_write_read();
    do_txn(0, 1'b1, 8'h10, 8'hA5, 0, "wr_10");
    do_txn(0, 1'b0, 8'h10, 8'h00, 0, "rd_10");
  endtask

  task automatic test_backpressure();
    do_txn(0, 1'b0, 8'h10, 8'h00, 5, "bp_rd_10");
  endtask

  task automatic test_out_of_range();
    do_txn(1, 1'b1, 8'h00, 8'h5A, 0, "oor_init");
    do_txn(1, 1'b1, 8'h20, 8'h77, 1, "oor_wr_20");
    do_txn(1, 1'b0, 8'h00, 8'h00, 0, "oor_rd_00");
    do_txn(1, 1'b1, 8'h0F, 8'hC3, 0, "edge_wr_0f");
    do_txn(1, 1'b0, 8'h0F, 8'h00, 0, "edge_rd_0f");
    do_txn(1, 1'b0, 8'h10, 8'h00, 2, "edge_rd_10");
  endtask

  task automatic test_reset_mid_write();
    do_txn(0, 1'b1, 8'h05, 8'h11, 0, "mid_init");
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 8'h05; rwd[0] = 8'h3C;
    @(posedge clk); @(negedge clk);
    rv[0] = 1'b0;
    rst_n[0] = 1'b0;
    #1;
    checks++;
    if (sv[0] !== 1'b0 || rrdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_asserted: got v=%b rdy=%b want v=0 rdy=0", sv[0], rrdy[0]);
    end
    @(posedge clk); @(negedge clk);
    rst_n[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (sv[0] !== 1'b0 || rrdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_idle: got v=%b rdy=%b want v=0 rdy=1", sv[0], rrdy[0]);
    end
    @(posedge clk); @(negedge clk);
    do_txn(0, 1'b0, 8'h05, 8'h00, 0, "mid_rd_05");
  endtask

  task automatic test_back_to_back();
    do_txn(1, 1'b1, 8'h03, 8'h96, 0, "b2b_wr_03");
    do_txn(1, 1'b0, 8'h03, 8'h00, 0, "b2b_rd_03");
    do_txn(1, 1'b0, 8'h00, 8'h00, 0, "b2b_rd_00");
    do_txn(1, 1'b0, 8'h03, 8'h00, 0, "b2b_rd_03b");
  endtask

  task automatic test_random();
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 30; n++) begin
        do_txn(d, 1'($urandom), 8'($urandom_range(0, 31)), 8'($urandom),
               int'($urandom_range(0, 3)), "rand");
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 256; a++) begin
        known[d][a] = 1'b0;
        model[d][a] = 8'h00;
      end
    test_reset();
    test_write_read();
    test_backpressure();
    test_out_of_range();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
